imm_gen_reg: RTL

//  Decode-stage immediate generator and pipeline register for the 64-bit LEGv8 pipeline.
//  - Takes the raw 32-bit instruction from the IF/ID register.
//  - Extracts the immediate field selected by the control unit and sign- or zero-extends it to 64 bits.
//  - Registers the result into the ID/EX boundary.
//  - Feeds the EX-stage ALU B-mux and the branch-target adder.
//  - Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/imm_gen_reg.sv | 101 ++++++++++
 1 files changed

// File: rtl/imm_gen_reg.sv
// ============================================================================
// Module      : imm_gen_reg
// Description : LEGv8 decode-stage immediate generator with ID/EX output
//               register, stall/flush support. Optional macro
//               IMMGEN_SEL_CHECK_EN enables the sticky illegal-select flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_reg #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [2:0]             imm_sel,
  output logic [DATA_WIDTH-1:0]  imm_out,
  output logic                   imm_valid,
  output logic [2:0]             sel_out,
  output logic                   sel_err
);

  localparam logic [2:0] SEL_DADDR9  = 3'd0;
  localparam logic [2:0] SEL_ALU12   = 3'd1;
  localparam logic [2:0] SEL_COND19  = 3'd2;
  localparam logic [2:0] SEL_BR26    = 3'd3;
  localparam logic [2:0] SEL_SHAMT   = 3'd4;
  localparam logic [2:0] SEL_MOV16   = 3'd5;

  logic [DATA_WIDTH-1:0] ext_daddr9;
  logic [DATA_WIDTH-1:0] ext_alu12;
  logic [DATA_WIDTH-1:0] ext_cond19;
  logic [DATA_WIDTH-1:0] ext_br26;
  logic [DATA_WIDTH-1:0] ext_shamt;
  logic [DATA_WIDTH-1:0] ext_mov16;
  logic [DATA_WIDTH-1:0] ext_val;
  logic [5:0]            mov_shift;
  logic                  load_en;
  logic                  unused_instr_bits;

  // Sign extension happens at full width before the branch-offset <<2,
  // so the shift simply drops the top bits.
  assign ext_daddr9 = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
  assign ext_alu12  = {{(DATA_WIDTH-12){1'b0}}, instr[21:10]};
  assign ext_cond19 = {{(DATA_WIDTH-19){instr[23]}}, instr[23:5]} << 2;
  assign ext_br26   = {{(DATA_WIDTH-26){instr[25]}}, instr[25:0]} << 2;
  assign ext_shamt  = {{(DATA_WIDTH-6){1'b0}}, instr[15:10]};
  assign mov_shift  = {instr[22:21], 4'b0000};
  assign ext_mov16  = {{(DATA_WIDTH-16){1'b0}}, instr[20:5]} << mov_shift;

  assign unused_instr_bits = ^instr[INSTR_WIDTH-1:26];

  always_comb begin
    ext_val = '0;
    case (imm_sel)
      SEL_DADDR9: ext_val = ext_daddr9;
      SEL_ALU12:  ext_val = ext_alu12;
      SEL_COND19: ext_val = ext_cond19;
      SEL_BR26:   ext_val = ext_br26;
      SEL_SHAMT:  ext_val = ext_shamt;
      SEL_MOV16:  ext_val = ext_mov16;
      default:    ext_val = '0;
    endcase
  end

  assign load_en = !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      imm_out   <= '0;
      imm_valid <= 1'b0;
      sel_out   <= 3'd0;
    end else if (!stall) begin
      imm_out   <= ext_val;
      imm_valid <= instr_valid;
      sel_out   <= imm_sel;
    end
  end

`ifdef IMMGEN_SEL_CHECK_EN
  // Sticky until reset; only real loads of valid instructions can trip it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (load_en && instr_valid && (imm_sel[2:1] == 2'b11)) begin
      sel_err <= 1'b1;
    end
  end
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
  assign sel_err        = 1'b0;
`endif

endmodule

`default_nettype wire
